// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemm_pkg
// Description : Shared constants and FSM state encoding for the GEMM tile
//               controller and its loop counter.
// Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

    // Default width of an SRAM word address
    localparam int C_ADDR_WIDTH = 12;

    // Default width of each tile-count input
    localparam int C_SIZE_WIDTH = 8;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DRAIN1 = 3'd2,
        DRAIN2 = 3'd3,
        DONE   = 3'd4
    } gemm_state_e;

endpackage
`default_nettype wire

// File: rtl/gemm_loop_counter.sv
`default_nettype none
// ============================================================================
// Module      : gemm_loop_counter
// Description : Nested m/n/k wrap counters (k innermost, then n, then m).
//               Exposes the k count and a last-step flag for every level.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_loop_counter
    import gemm_pkg::*;
#(
    parameter int SIZE_W = C_SIZE_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [SIZE_W-1:0] i_m_size,
    input  logic [SIZE_W-1:0] i_k_size,
    input  logic [SIZE_W-1:0] i_n_size,
    output logic [SIZE_W-1:0] o_k,
    output logic              o_m_last,
    output logic              o_n_last,
    output logic              o_k_last
);

    logic [SIZE_W-1:0] r_m;
    logic [SIZE_W-1:0] r_n;
    logic [SIZE_W-1:0] r_k;

    assign o_k      = r_k;
    assign o_m_last = (r_m == i_m_size - SIZE_W'(1));
    assign o_n_last = (r_n == i_n_size - SIZE_W'(1));
    assign o_k_last = (r_k == i_k_size - SIZE_W'(1));

    // Advance k every step; carry into n and then m on wrap. The final step
    // wraps all three back to zero so the next run starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (i_clear) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (i_step) begin
            if (o_k_last) begin
                r_k <= '0;
                if (o_n_last) begin
                    r_n <= '0;
                    r_m <= o_m_last ? '0 : r_m + SIZE_W'(1);
                end else begin
                    r_n <= r_n + SIZE_W'(1);
                end
            end else begin
                r_k <= r_k + SIZE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gemm_tile_controller.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_controller
// Description : Sequences one GEMM over M x N x K tiles. Issues one A/B read
//               per cycle, flags first/last K step to the PE one cycle later,
//               and writes each finished C tile the cycle after its last step.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_controller
    import gemm_pkg::*;
#(
    parameter int AddrWidth     = C_ADDR_WIDTH,
    parameter int SizeAddrWidth = C_SIZE_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_first_o,
    output logic                     mac_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    gemm_state_e              r_state;
    logic [SizeAddrWidth-1:0] r_m_size;
    logic [SizeAddrWidth-1:0] r_k_size;
    logic [SizeAddrWidth-1:0] r_n_size;
    logic [AddrWidth-1:0]     r_a_base;
    logic [AddrWidth-1:0]     r_b_base;
    logic [AddrWidth-1:0]     r_c_cnt;
    logic [AddrWidth-1:0]     r_c_addr;
    logic                     r_c_we;
    logic                     r_mac_valid;
    logic                     r_mac_first;
    logic                     r_mac_last;
    logic                     r_busy;
    logic                     r_done;

    logic [SizeAddrWidth-1:0] w_k;
    logic                     w_m_last;
    logic                     w_n_last;
    logic                     w_k_last;
    logic                     w_step;
    logic                     w_start;
    logic                     w_zero;
    logic                     w_final;
    logic [AddrWidth-1:0]     w_k_ext;
    logic [AddrWidth-1:0]     w_k_size_ext;

    assign w_step       = (r_state == RUN);
    assign w_start      = (r_state == IDLE) && start_i;
    assign w_zero       = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    assign w_final      = w_step && w_k_last && w_n_last && w_m_last;
    assign w_k_ext      = AddrWidth'(w_k);
    assign w_k_size_ext = AddrWidth'(r_k_size);

    gemm_loop_counter #(
        .SIZE_W (SizeAddrWidth)
    ) u_loop (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .i_clear  (w_start),
        .i_step   (w_step),
        .i_m_size (r_m_size),
        .i_k_size (r_k_size),
        .i_n_size (r_n_size),
        .o_k      (w_k),
        .o_m_last (w_m_last),
        .o_n_last (w_n_last),
        .o_k_last (w_k_last)
    );

    // Read addresses exist only while issuing; zero otherwise
    assign sram_a_addr_o = w_step ? (r_a_base + w_k_ext) : '0;
    assign sram_b_addr_o = w_step ? (r_b_base + w_k_ext) : '0;
    assign sram_c_addr_o = r_c_addr;
    assign sram_c_we_o   = r_c_we;
    assign mac_valid_o   = r_mac_valid;
    assign mac_first_o   = r_mac_first;
    assign mac_last_o    = r_mac_last;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

    // Control FSM with registered busy/done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_busy <= 1'b1;
                        if (w_zero) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_final) begin
                        r_state <= DRAIN1;
                    end
                end
                DRAIN1: begin
                    r_state <= DRAIN2;
                end
                DRAIN2: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Size latch, running address bases, PE strobes and C write pipeline
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m_size    <= '0;
            r_k_size    <= '0;
            r_n_size    <= '0;
            r_a_base    <= '0;
            r_b_base    <= '0;
            r_c_cnt     <= '0;
            r_c_addr    <= '0;
            r_c_we      <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
        end else begin
            if (w_start) begin
                r_m_size <= M_size_i;
                r_k_size <= K_size_i;
                r_n_size <= N_size_i;
                r_a_base <= '0;
                r_b_base <= '0;
                r_c_cnt  <= '0;
            end else if (w_step && w_k_last) begin
                // One (m,n) tile finished: move B to the next column, or wrap
                // B and move A to the next row
                if (w_n_last) begin
                    r_b_base <= '0;
                    r_a_base <= w_m_last ? '0 : r_a_base + w_k_size_ext;
                end else begin
                    r_b_base <= r_b_base + w_k_size_ext;
                end
            end

            r_mac_valid <= w_step;
            r_mac_first <= w_step && (w_k == '0);
            r_mac_last  <= w_step && w_k_last;

            // C tile is written the cycle after the PE sees its last K step
            if (r_mac_last) begin
                r_c_we   <= 1'b1;
                r_c_addr <= r_c_cnt;
                r_c_cnt  <= r_c_cnt + AddrWidth'(1);
            end else begin
                r_c_we   <= 1'b0;
                r_c_addr <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm_tile_controller
// Description : Scoreboard bench for gemm_tile_controller. Stimulus pushes
//               expected issues, writes and done cycles; a monitor pops and
//               compares them as the DUT presents outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_controller;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  m_sz  = '0;
    logic [7:0]  k_sz  = '0;
    logic [7:0]  n_sz  = '0;
    logic [11:0] a_addr;
    logic [11:0] b_addr;
    logic [11:0] c_addr;
    logic        we;
    logic        mv;
    logic        mf;
    logic        ml;
    logic        busy;
    logic        done;

    gemm_tile_controller #(
        .AddrWidth     (12),
        .SizeAddrWidth (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .M_size_i      (m_sz),
        .K_size_i      (k_sz),
        .N_size_i      (n_sz),
        .sram_a_addr_o (a_addr),
        .sram_b_addr_o (b_addr),
        .sram_c_addr_o (c_addr),
        .sram_c_we_o   (we),
        .mac_valid_o   (mv),
        .mac_first_o   (mf),
        .mac_last_o    (ml),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        bit first;
        bit last;
        int cyc;
    } iss_t;

    typedef struct {
        int c;
        int cyc;
    } wr_t;

    iss_t iss_q[$];
    wr_t  wr_q[$];
    int   done_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard every cycle
    int   prev_a = 0;
    int   prev_b = 0;
    iss_t mon_e;
    wr_t  mon_w;
    int   mon_d;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mv) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mon_e = iss_q.pop_front();
                    chk("issue_a", prev_a, mon_e.a);
                    chk("issue_b", prev_b, mon_e.b);
                    chk("mac_first", int'(mf), int'(mon_e.first));
                    chk("mac_last", int'(ml), int'(mon_e.last));
                    chk("valid_cycle", cyc, mon_e.cyc);
                end
            end else begin
                chk("strobe_without_valid", int'(mf | ml), 0);
            end
            if (!busy) begin
                chk("ab_addr_idle", int'(a_addr | b_addr), 0);
            end
            if (we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("c_addr", int'(c_addr), mon_w.c);
                    chk("we_cycle", cyc, mon_w.cyc);
                end
            end else begin
                chk("c_addr_no_we", int'(c_addr), 0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_cycle", cyc, mon_d);
                    chk("busy_at_done", int'(busy), 1);
                end
            end
            prev_a = int'(a_addr);
            prev_b = int'(b_addr);
        end
    end

    // Expected response of one GEMM accepted in cycle t
    task automatic push_run(input int t, input int M, input int K, input int N);
        int idx;
        idx = 0;
        if (M == 0 || K == 0 || N == 0) begin
            done_q.push_back(t + 1);
        end else begin
            for (int m = 0; m < M; m++) begin
                for (int n = 0; n < N; n++) begin
                    for (int k = 0; k < K; k++) begin
                        iss_t e;
                        e.a     = (m * K + k) % 4096;
                        e.b     = (n * K + k) % 4096;
                        e.first = (k == 0);
                        e.last  = (k == K - 1);
                        e.cyc   = t + 2 + idx;
                        iss_q.push_back(e);
                        idx++;
                    end
                    begin
                        wr_t w;
                        w.c   = (m * N + n) % 4096;
                        w.cyc = t + (m * N + n + 1) * K + 2;
                        wr_q.push_back(w);
                    end
                end
            end
            done_q.push_back(t + M * N * K + 3);
        end
    endtask

    // Start a GEMM; with hold, start stays high so a second run follows
    task automatic launch(input int M, input int K, input int N, input bit hold);
        int t;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b1;
        m_sz  = 8'(M);
        k_sz  = 8'(K);
        n_sz  = 8'(N);
        push_run(t, M, K, N);
        if (hold) begin
            push_run(t + M * N * K + 4, M, K, N);
            repeat (M * N * K + 5) @(posedge clk);
        end else begin
            @(posedge clk);
        end
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(done_q.size() == 0 && busy === 1'b0)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > budget) begin
                chk("timeout", 1, 0);
                done_q.delete();
                iss_q.delete();
                wr_q.delete();
                break;
            end
        end
        chk("issues_left", iss_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, int'(a_addr), 0);
        chk({tag, "_b"}, int'(b_addr), 0);
        chk({tag, "_c"}, int'(c_addr), 0);
        chk({tag, "_we"}, int'(we), 0);
        chk({tag, "_valid"}, int'(mv), 0);
        chk({tag, "_first"}, int'(mf), 0);
        chk({tag, "_last"}, int'(ml), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // Single tile
        launch(1, 1, 1, 1'b0);
        wait_idle(50);

        // One row of A reused across four B columns
        launch(1, 16, 4, 1'b0);
        wait_idle(200);

        // Full 8x8x8
        launch(8, 8, 8, 1'b0);
        wait_idle(1000);

        // Zero K: immediate done, one busy cycle, nothing issued
        launch(4, 0, 4, 1'b0);
        wait_idle(20);
        chk("busy_after_zero", int'(busy), 0);

        // Start pulse with other sizes while running is ignored
        launch(2, 3, 2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        m_sz  = 8'd1;
        k_sz  = 8'd1;
        n_sz  = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(100);

        // Start held high through DONE restarts on the next IDLE cycle
        launch(1, 2, 1, 1'b1);
        wait_idle(100);

        // Reset in the middle of a run
        launch(2, 4, 3, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        iss_q.delete();
        wr_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fresh run after reset starts again from address 0
        launch(1, 2, 2, 1'b0);
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
